// File: rtl/atomic_counter_bank.sv
// Bank of independent counters with a shared snapshot register. An atomic
// read latches one full counter so its words can be read back consistently.
module atomic_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int DATABUS   = 32,
  parameter int COUNTLEN  = 64,
  parameter int FAST_STEP = 1000000,
  parameter int SATURATE  = 0,
  localparam int NWORDS   = COUNTLEN / DATABUS,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WORD_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   trig_i,
  input  logic [NUM_CH-1:0]   fast_i,
  input  logic [NUM_CH-1:0]   clr_i,
  input  logic                req_i,
  input  logic                atomic_i,
  input  logic [CH_W-1:0]     ch_i,
  input  logic [WORD_W-1:0]   word_i,
  output logic                ack_o,
  output logic [DATABUS-1:0]  count_o,
  output logic                err_o,
  output logic [NUM_CH-1:0]   ovf_o
);

  localparam int SUM_W = COUNTLEN + 1;
  localparam logic [COUNTLEN:0] FAST_INC = SUM_W'(FAST_STEP);
  localparam logic [COUNTLEN:0] SLOW_INC = SUM_W'(1);

  logic [COUNTLEN-1:0]              cnt [NUM_CH];
  logic [COUNTLEN:0]                sum [NUM_CH];
  logic [NWORDS-1:0][DATABUS-1:0]   snap;
  logic                             snap_valid;

  logic [COUNTLEN-1:0] sel_cnt;
  logic                ch_ok;
  logic [DATABUS-1:0]  word_data;
  logic                word_ok;

  // One extra bit on every adder so the carry-out directly flags overflow.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c] = {1'b0, cnt[c]} + (fast_i[c] ? FAST_INC : SLOW_INC);
    end
  end

  always_comb begin
    sel_cnt   = '0;
    ch_ok     = 1'b0;
    word_data = '0;
    word_ok   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(ch_i) == c) begin
        sel_cnt = cnt[c];
        ch_ok   = 1'b1;
      end
    end
    for (int w = 0; w < NWORDS; w++) begin
      if (int'(word_i) == w) begin
        word_data = snap[w];
        word_ok   = 1'b1;
      end
    end
  end

  // Clear wins over increment, and also drops a same-cycle overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] <= '0;
      end
      ovf_o <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr_i[c]) begin
          cnt[c]   <= '0;
          ovf_o[c] <= 1'b0;
        end else if (trig_i[c]) begin
          if (sum[c][COUNTLEN]) begin
            ovf_o[c] <= 1'b1;
            if (SATURATE != 0) begin
              cnt[c] <= '1;
            end else begin
              cnt[c] <= sum[c][COUNTLEN-1:0];
            end
          end else begin
            cnt[c] <= sum[c][COUNTLEN-1:0];
          end
        end
      end
    end
  end

  // Atomic reads capture the pre-increment value because cnt is sampled here.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap       <= '0;
      snap_valid <= 1'b0;
      ack_o      <= 1'b0;
      count_o    <= '0;
      err_o      <= 1'b0;
    end else begin
      ack_o   <= req_i;
      count_o <= '0;
      err_o   <= 1'b0;
      if (req_i) begin
        if (atomic_i) begin
          if (ch_ok) begin
            snap       <= sel_cnt;
            snap_valid <= 1'b1;
            count_o    <= sel_cnt[DATABUS-1:0];
          end else begin
            err_o <= 1'b1;
          end
        end else if (word_ok && snap_valid) begin
          count_o <= word_data;
        end else begin
          err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Drives three configurations (wide wrap, narrow wrap, narrow saturate) from one
// stimulus stream and compares every output each cycle with an arithmetic model.
module tb_atomic_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] trig, fast, clr;
  logic       req, atomic;
  logic [1:0] ch, word;

  logic        m_ack, m_err;
  logic [31:0] m_count;
  logic [3:0]  m_ovf;
  logic        s_ack, s_err;
  logic [7:0]  s_count;
  logic [2:0]  s_ovf;
  logic        t_ack, t_err;
  logic [7:0]  t_count;
  logic [2:0]  t_ovf;

  atomic_counter_bank #(
    .NUM_CH(4), .DATABUS(32), .COUNTLEN(64), .FAST_STEP(1000000), .SATURATE(0)
  ) u_main (
    .clk(clk), .reset(reset), .trig_i(trig), .fast_i(fast), .clr_i(clr),
    .req_i(req), .atomic_i(atomic), .ch_i(ch), .word_i(word[0:0]),
    .ack_o(m_ack), .count_o(m_count), .err_o(m_err), .ovf_o(m_ovf)
  );

  atomic_counter_bank #(
    .NUM_CH(3), .DATABUS(8), .COUNTLEN(24), .FAST_STEP(16776960), .SATURATE(0)
  ) u_wrap (
    .clk(clk), .reset(reset), .trig_i(trig[2:0]), .fast_i(fast[2:0]), .clr_i(clr[2:0]),
    .req_i(req), .atomic_i(atomic), .ch_i(ch), .word_i(word),
    .ack_o(s_ack), .count_o(s_count), .err_o(s_err), .ovf_o(s_ovf)
  );

  atomic_counter_bank #(
    .NUM_CH(3), .DATABUS(8), .COUNTLEN(24), .FAST_STEP(16776960), .SATURATE(1)
  ) u_sat (
    .clk(clk), .reset(reset), .trig_i(trig[2:0]), .fast_i(fast[2:0]), .clr_i(clr[2:0]),
    .req_i(req), .atomic_i(atomic), .ch_i(ch), .word_i(word),
    .ack_o(t_ack), .count_o(t_count), .err_o(t_err), .ovf_o(t_ovf)
  );

  // Model configuration per instance: 0 = u_main, 1 = u_wrap, 2 = u_sat.
  int unsigned       nch[3]   = '{4, 3, 3};
  int unsigned       dbw[3]   = '{32, 8, 8};
  int unsigned       clen[3]  = '{64, 24, 24};
  longint unsigned   fstep[3] = '{64'd1000000, 64'd16776960, 64'd16776960};
  bit                sat[3]   = '{1'b0, 1'b0, 1'b1};

  logic [63:0] mcnt[3][4];
  bit          movf[3][4];
  logic [63:0] msnap[3];
  bit          mvalid[3];
  bit          eack[3];
  logic [63:0] edata[3];
  bit          eerr[3];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic updateModel();
    for (int k = 0; k < 3; k++) begin
      logic [64:0] limit, sum, wrapped;
      logic [63:0] dmask, shifted;
      int unsigned wd, nw;
      limit = (65'd1 << clen[k]) - 65'd1;
      dmask = (64'd1 << dbw[k]) - 64'd1;
      nw    = clen[k] / dbw[k];
      wd    = (k == 0) ? int'(word[0]) : int'(word);
      eack[k]  = 1'b0;
      edata[k] = '0;
      eerr[k]  = 1'b0;
      if (reset) begin
        for (int c = 0; c < 4; c++) begin
          mcnt[k][c] = '0;
          movf[k][c] = 1'b0;
        end
        msnap[k]  = '0;
        mvalid[k] = 1'b0;
      end else begin
        if (req) begin
          eack[k] = 1'b1;
          if (atomic) begin
            if (int'(ch) < nch[k]) begin
              msnap[k]  = mcnt[k][ch];
              mvalid[k] = 1'b1;
              edata[k]  = msnap[k] & dmask;
            end else begin
              eerr[k] = 1'b1;
            end
          end else if (wd < nw && mvalid[k]) begin
            shifted  = msnap[k] >> (wd * dbw[k]);
            edata[k] = shifted & dmask;
          end else begin
            eerr[k] = 1'b1;
          end
        end
        for (int c = 0; c < 4; c++) begin
          if (c < nch[k]) begin
            if (clr[c]) begin
              mcnt[k][c] = '0;
              movf[k][c] = 1'b0;
            end else if (trig[c]) begin
              sum = {1'b0, mcnt[k][c]} + 65'(fast[c] ? fstep[k] : 64'd1);
              if (sum > limit) begin
                movf[k][c] = 1'b1;
                wrapped    = sat[k] ? limit : (sum & limit);
              end else begin
                wrapped = sum;
              end
              mcnt[k][c] = wrapped[63:0];
            end
          end
        end
      end
    end
  endtask

  task automatic compareAll();
    for (int k = 0; k < 3; k++) begin
      logic        a, e;
      logic [63:0] d;
      logic [3:0]  o, eo;
      case (k)
        0:       begin a = m_ack; e = m_err; d = 64'(m_count); o = m_ovf; end
        1:       begin a = s_ack; e = s_err; d = 64'(s_count); o = {1'b0, s_ovf}; end
        default: begin a = t_ack; e = t_err; d = 64'(t_count); o = {1'b0, t_ovf}; end
      endcase
      eo = '0;
      for (int c = 0; c < 4; c++) begin
        if (c < nch[k]) eo[c] = movf[k][c];
      end
      checkOutput($sformatf("ack%0d", k), 64'(a), 64'(eack[k]));
      checkOutput($sformatf("err%0d", k), 64'(e), 64'(eerr[k]));
      checkOutput($sformatf("count%0d", k), d, edata[k]);
      checkOutput($sformatf("ovf%0d", k), 64'(o), 64'(eo));
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [3:0] tr, input logic [3:0] fa,
                               input logic [3:0] cl, input bit rq, input bit at,
                               input logic [1:0] c, input logic [1:0] w);
    reset  = r;
    trig   = tr;
    fast   = fa;
    clr    = cl;
    req    = rq;
    atomic = at;
    ch     = c;
    word   = w;
    updateModel();
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 4'h0, 4'h0, 4'h0, 0, 0, 2'd0, 2'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] big;
    applyStimulus(1, 4'h0, 4'h0, 4'h0, 0, 0, 2'd0, 2'd0);
    applyStimulus(1, 4'h0, 4'h0, 4'h0, 0, 0, 2'd0, 2'd0);
    checkOutput("rst_ack", 64'(m_ack), 64'd0);
    checkOutput("rst_ovf", 64'(m_ovf), 64'd0);

    // Reading before any snapshot exists is an error.
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 0, 2'd0, 2'd0);
    checkOutput("nosnap_ack", 64'(m_ack), 64'd1);
    checkOutput("nosnap_err", 64'(m_err), 64'd1);
    checkOutput("nosnap_data", 64'(m_count), 64'd0);

    // Channel 2 fast-stepped 4295 times crosses the 32-bit word boundary.
    repeat (4295) applyStimulus(0, 4'b0100, 4'b0100, 4'h0, 0, 0, 2'd0, 2'd0);
    big = 64'd4295 * 64'd1000000;
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'd2, 2'd0);
    checkOutput("fast_w0", 64'(m_count), 64'(big[31:0]));
    checkOutput("fast_w0_err", 64'(m_err), 64'd0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 0, 2'd0, 2'd1);
    checkOutput("fast_w1", 64'(m_count), 64'(big[63:32]));
    checkOutput("fast_w1_err", 64'(m_err), 64'd0);

    // Snapshot with a same-cycle trigger, then later increments must not leak in.
    applyStimulus(0, 4'h0, 4'h0, 4'b0001, 0, 0, 2'd0, 2'd0);
    repeat (255) applyStimulus(0, 4'b0001, 4'h0, 4'h0, 0, 0, 2'd0, 2'd0);
    applyStimulus(0, 4'b0001, 4'h0, 4'h0, 1, 1, 2'd0, 2'd0);
    checkOutput("iso_w0_narrow", 64'(s_count), 64'hFF);
    checkOutput("iso_w0_wide", 64'(m_count), 64'd255);
    repeat (10) applyStimulus(0, 4'b0001, 4'h0, 4'h0, 0, 0, 2'd0, 2'd0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 0, 2'd0, 2'd1);
    checkOutput("iso_w1_narrow", 64'(s_count), 64'h00);
    checkOutput("iso_w1_wide", 64'(m_count), 64'd0);

    // Out-of-range word and channel; a rejected atomic read keeps the old snapshot.
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 0, 2'd0, 2'd3);
    checkOutput("badword_err", 64'(s_err), 64'd1);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'd3, 2'd0);
    checkOutput("badch_err", 64'(s_err), 64'd1);
    checkOutput("badch_data", 64'(s_count), 64'd0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 0, 2'd0, 2'd0);
    checkOutput("badch_keep", 64'(s_count), 64'hFF);

    // Overflow on the 24-bit configurations: wrap versus saturate.
    applyStimulus(0, 4'h0, 4'h0, 4'b0010, 0, 0, 2'd0, 2'd0);
    applyStimulus(0, 4'b0010, 4'b0010, 4'h0, 0, 0, 2'd0, 2'd0);
    repeat (255) applyStimulus(0, 4'b0010, 4'h0, 4'h0, 0, 0, 2'd0, 2'd0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'd1, 2'd0);
    checkOutput("full_wrap", 64'(s_count), 64'hFF);
    applyStimulus(0, 4'b0010, 4'h0, 4'h0, 0, 0, 2'd0, 2'd0);
    checkOutput("ovf_wrap", 64'(s_ovf[1]), 64'd1);
    checkOutput("ovf_sat", 64'(t_ovf[1]), 64'd1);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'd1, 2'd0);
    checkOutput("after_wrap", 64'(s_count), 64'h00);
    checkOutput("after_sat", 64'(t_count), 64'hFF);
    applyStimulus(0, 4'b0010, 4'h0, 4'h0, 1, 0, 2'd0, 2'd2);
    checkOutput("sat_w2", 64'(t_count), 64'hFF);
    checkOutput("sat_sticky", 64'(t_ovf[1]), 64'd1);
    applyStimulus(0, 4'h0, 4'h0, 4'b0010, 0, 0, 2'd0, 2'd0);
    checkOutput("clr_ovf_wrap", 64'(s_ovf[1]), 64'd0);
    checkOutput("clr_ovf_sat", 64'(t_ovf[1]), 64'd0);

    // Clear and trigger together on channel 3 leave it at zero.
    repeat (3) applyStimulus(0, 4'b1000, 4'h0, 4'h0, 0, 0, 2'd0, 2'd0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'd3, 2'd0);
    checkOutput("ch3_three", 64'(m_count), 64'd3);
    applyStimulus(0, 4'b1000, 4'h0, 4'b1000, 0, 0, 2'd0, 2'd0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'd3, 2'd0);
    checkOutput("ch3_clr_trig", 64'(m_count), 64'd0);

    // Five back-to-back requests alternating atomic and word reads.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, (i % 2) == 0, 2'd2, 2'((i % 2)));
      checkOutput($sformatf("b2b_ack%0d", i), 64'(m_ack), 64'd1);
      checkOutput($sformatf("b2b_data%0d", i), 64'(m_count),
                  (i % 2) == 0 ? 64'(big[31:0]) : 64'(big[63:32]));
    end

    // Reset between an atomic read and its word read.
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'd2, 2'd0);
    applyStimulus(1, 4'hF, 4'h0, 4'h0, 1, 0, 2'd0, 2'd1);
    checkOutput("rst_req_dropped", 64'(m_ack), 64'd0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 0, 2'd0, 2'd1);
    checkOutput("rst_snap_err", 64'(m_err), 64'd1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'(c), 2'd0);
      checkOutput($sformatf("rst_cnt%0d", c), 64'(m_count), 64'd0);
    end
    checkOutput("rst_ovf_all", 64'(m_ovf), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 199) == 0, 4'($urandom), 4'($urandom),
                    ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0,
                    1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
